bus_initiator: RTL and testbench
================================

Name: bus_initiator

Overview:
- Synchronous 6502-style bus master for the fpga-floppy system bus.
- Converts single-beat host requests (address, read/write, write data) into bus cycles aligned to the phi_0 system clock from clock_gen.
- Drives the shared address, RW and write-data lines seen by the 8K SRAM, 32K ROM and future FDC registers. Returns read data and status to the host.
- Supports RDY wait-state stretching with a timeout.

Parameters:
- ADDR_W, 16, bus address width.
- DATA_W, 8, bus data width.
- MAX_WAIT, 255, maximum stretched phi_0 cycles before a wait timeout aborts the transfer.

Ports:
- clk  in  1  system clock, same domain as clock_gen.
- rst  in  1  synchronous reset, active-low.
- phi_0  in  1  system bus clock from clock_gen; high phase = data phase.
- req_valid  in  1  host request valid.
- req_ready  out  1  request accepted when req_valid and req_ready are both high on a clk edge.
- req_rw  in  1  1 = read, 0 = write.
- req_addr  in  ADDR_W  request address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-clk pulse; the transfer has completed.
- rsp_rdata  out  DATA_W  read data; valid while rsp_valid is high, held until the next response.
- rsp_err  out  1  set with rsp_valid if the transfer ended by wait timeout.
- bus_addr  out  ADDR_W  bus address.
- bus_rw  out  1  bus RW, 1 = read.
- bus_wdata  out  DATA_W  write data to devices.
- bus_data_oe  out  1  master drives the data bus.
- bus_rdata  in  DATA_W  read data from the decoded device.
- bus_rdy  in  1  device ready; low at the end of phi_0 high stretches the cycle.

Behaviour:
- Edge detection: phi_q is a registered copy of phi_0. rise = ~phi_q & phi_0; fall = phi_q & ~phi_0. Both are evaluated combinationally in the clk domain.
- Reset (rst low at a clk edge), values on the next edge:
  - bus_addr = 0, bus_rw = 1, bus_wdata = 0, bus_data_oe = 0.
  - req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - wait counter = 0, FSM = IDLE.
  - Reset mid-transfer abandons the transfer with no response.
- FSM states: IDLE, PEND, ADDR, DATA.
- IDLE: req_ready = 1. On handshake, latch rw, addr and wdata into the holding register and go to PEND; req_ready = 0 from the next cycle.
- PEND: wait for fall. On fall, drive bus_addr and bus_rw from the holding register and go to ADDR. For a write, also drive bus_wdata and set bus_data_oe = 1.
- ADDR: wait for rise, then go to DATA. Bus outputs are held.
- DATA, on fall:
  - If bus_rdy is 1 or the transfer is a write: capture bus_rdata for reads, pulse rsp_valid, rsp_err = 0.
  - Writes ignore RDY (6502 semantics).
  - If bus_rdy is 0 on a read: increment the wait counter, stay in the cycle and go back to ADDR with the bus held. When the counter reaches MAX_WAIT, complete with rsp_err = 1 and rsp_rdata = 0.
- Completion (same edge as the fall):
  - bus_rw returns to 1, bus_data_oe = 0, bus_addr holds its value.
  - Wait counter clears and the FSM returns to IDLE; req_ready = 1 on the following cycle.
- Throughput: the earliest next bus cycle starts at the next fall after a new request. Minimum spacing is one idle phi_0 period between transfers, so back-to-back cycles are not allowed.
- A request accepted while phi_0 is mid-period never disturbs the bus before the next fall.
- phi_0 held static: the FSM waits indefinitely except in stretched reads, which count only fall events.
- The write enable to SRAM is generated outside this block as ~bus_rw & phi_0.
- Simultaneous reset and handshake: reset wins.

Decomposition:
- Shared package bus_pkg:
  - RW_READ = 1, RW_WRITE = 0.
  - Address-map constants: SRAM $0000-$1FFF, ROM $8000-$FFFF.
  - FSM state encoding.
- One natural sub-module: phi_edge_det, which registers phi_0 and outputs rise and fall. It is reused by future FDC register blocks.

Test Plan:
- Read ROM: preload ROM[$8000] = $4C; request read $8000 -> bus_addr = $8000 and bus_rw = 1 from the first fall; rsp_valid one clk after the next fall with rsp_rdata = $4C and rsp_err = 0.
- Write then read SRAM: write $AA to $0000, then read $0000 -> bus_data_oe = 1 only during the write cycle, bus_wdata = $AA; the read returns $AA. Repeat with $55 at $1FFF.
- Wait states: read $0010 with bus_rdy held low for 3 falls -> the cycle stretches exactly 3 phi_0 periods with bus_addr stable, then returns the correct data with rsp_err = 0.
- Timeout: MAX_WAIT = 4 with bus_rdy stuck at 0 -> rsp_valid after 4 stretched periods, rsp_err = 1, rsp_rdata = 0, FSM back in IDLE.
- Unmapped read $4000 with bus_rdata = $FF (floating) -> rsp_rdata = $FF, no error.
- Reset mid-cycle: assert rst low during DATA of a write -> next clk has bus_data_oe = 0, bus_rw = 1, req_ready = 1 and no rsp_valid pulse.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the fpga-floppy system bus: RW encoding, address map
// and the bus initiator state encoding.
package bus_pkg;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam logic [15:0] SRAM_BASE = 16'h0000;
  localparam logic [15:0] SRAM_LAST = 16'h1FFF;
  localparam logic [15:0] ROM_BASE  = 16'h8000;
  localparam logic [15:0] ROM_LAST  = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_ADDR = 2'd2,
    ST_DATA = 2'd3
  } bus_state_e;

endpackage

// File: rtl/phi_edge_det.sv
// Registers phi_0 in the clk domain and flags its rising and falling edges.
module phi_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic phi_0,
  output logic rise,
  output logic fall
);

  logic phi_q;

  always_ff @(posedge clk) begin
    if (!rst) phi_q <= 1'b0;
    else      phi_q <= phi_0;
  end

  assign rise = ~phi_q & phi_0;
  assign fall = phi_q & ~phi_0;

endmodule

// File: rtl/bus_initiator.sv
// 6502-style single-beat bus master: turns host requests into phi_0-aligned
// bus cycles with RDY stretching and a wait timeout.
module bus_initiator
  import bus_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 8,
  parameter int MAX_WAIT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              phi_0,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_rw,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              bus_data_oe,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_rdy
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  logic rise, fall;

  phi_edge_det u_edge (
    .clk   (clk),
    .rst   (rst),
    .phi_0 (phi_0),
    .rise  (rise),
    .fall  (fall)
  );

  bus_state_e        state, state_nxt;
  logic              hold_rw;
  logic [ADDR_W-1:0] hold_addr;
  logic [DATA_W-1:0] hold_wdata;
  logic [CNT_W-1:0]  wait_cnt;
  logic              hs, complete, stretch, timeout;

  assign req_ready = (state == ST_IDLE);
  assign hs        = req_valid & req_ready;

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    complete  = 1'b0;
    stretch   = 1'b0;
    timeout   = 1'b0;
    case (state)
      ST_IDLE: if (hs)   state_nxt = ST_PEND;
      ST_PEND: if (fall) state_nxt = ST_ADDR;
      ST_ADDR: if (rise) state_nxt = ST_DATA;
      ST_DATA: begin
        if (fall) begin
          // Writes never stretch; only reads honour RDY.
          if (bus_rdy || hold_rw == RW_WRITE) begin
            complete  = 1'b1;
            state_nxt = ST_IDLE;
          end else if (wait_cnt == CNT_W'(MAX_WAIT)) begin
            complete  = 1'b1;
            timeout   = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            stretch   = 1'b1;
            state_nxt = ST_ADDR;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_rw     <= RW_READ;
      hold_addr   <= '0;
      hold_wdata  <= '0;
      wait_cnt    <= '0;
      bus_addr    <= '0;
      bus_rw      <= RW_READ;
      bus_wdata   <= '0;
      bus_data_oe <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (hs) begin
        hold_rw    <= req_rw;
        hold_addr  <= req_addr;
        hold_wdata <= req_wdata;
      end
      // The bus is only ever launched on a fall, so a mid-period request
      // cannot glitch the shared lines.
      if (state == ST_PEND && fall) begin
        bus_addr <= hold_addr;
        bus_rw   <= hold_rw;
        if (hold_rw == RW_WRITE) begin
          bus_wdata   <= hold_wdata;
          bus_data_oe <= 1'b1;
        end
      end
      if (stretch) wait_cnt <= wait_cnt + 1'b1;
      if (complete) begin
        rsp_valid   <= 1'b1;
        rsp_err     <= timeout;
        wait_cnt    <= '0;
        bus_rw      <= RW_READ;
        bus_data_oe <= 1'b0;
        if (hold_rw == RW_READ) rsp_rdata <= timeout ? '0 : bus_rdata;
      end
    end
  end

endmodule

// File: tb/tb_bus_initiator.sv
// Directed bench for bus_initiator with a small SRAM/ROM bus model.
module tb_bus_initiator;
  import bus_pkg::*;

  logic        clk, rst, phi_0;
  logic        req_valid, req_ready, req_rw;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid, rsp_err;
  logic [7:0]  rsp_rdata;
  logic [15:0] bus_addr;
  logic        bus_rw, bus_data_oe, bus_rdy;
  logic [7:0]  bus_wdata, bus_rdata;

  int checks = 0;
  int errors = 0;

  bus_initiator #(.ADDR_W(16), .DATA_W(8), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst), .phi_0(phi_0),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .bus_addr(bus_addr), .bus_rw(bus_rw), .bus_wdata(bus_wdata),
    .bus_data_oe(bus_data_oe), .bus_rdata(bus_rdata), .bus_rdy(bus_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus model: SRAM written on ~rw & phi_0, ROM preloaded, holes float high.
  logic [7:0] sram [0:8191];
  logic [7:0] rom  [0:32767];
  assign bus_rdata = (bus_addr <= SRAM_LAST) ? sram[bus_addr[12:0]] :
                     (bus_addr >= ROM_BASE)  ? rom[bus_addr[14:0]]  : 8'hFF;
  always @(posedge clk)
    if (!bus_rw && phi_0 && bus_addr <= SRAM_LAST) sram[bus_addr[12:0]] <= bus_wdata;

  logic a_ok, oe_s, wd_ok, rw_fall;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic obs(input logic [15:0] a, input logic rw, input logic [7:0] wd);
    if (bus_addr !== a) a_ok = 1'b0;
    if (bus_data_oe === 1'b1) oe_s = 1'b1;
    if (rw == RW_WRITE && bus_wdata !== wd) wd_ok = 1'b0;
  endtask

  // One full transfer; lows = number of DATA falls with RDY held low.
  task automatic xfer(input logic rw, input logic [15:0] a, input logic [7:0] wd,
                      input int lows, output logic [7:0] rd, output logic err,
                      output int stretches, output logic done);
    int dfalls;
    int left;
    left = lows; dfalls = 0; done = 1'b0; rd = 8'h00; err = 1'b0;
    a_ok = 1'b1; oe_s = 1'b0; wd_ok = 1'b1;
    phi_0 = 1'b1; tick(); tick();
    req_valid = 1'b1; req_rw = rw; req_addr = a; req_wdata = wd;
    tick();
    req_valid = 1'b0;
    phi_0 = 1'b0; tick();
    rw_fall = bus_rw;
    obs(a, rw, wd);
    repeat (3) begin tick(); obs(a, rw, wd); end
    phi_0 = 1'b1;
    repeat (4) begin tick(); obs(a, rw, wd); end
    for (int p = 0; p < 20 && !done; p++) begin
      bus_rdy = (left == 0);
      if (left > 0) left--;
      phi_0 = 1'b0; tick();
      dfalls++;
      if (rsp_valid === 1'b1) begin
        done = 1'b1; rd = rsp_rdata; err = rsp_err;
      end else begin
        obs(a, rw, wd);
        repeat (3) begin tick(); obs(a, rw, wd); end
        phi_0 = 1'b1;
        repeat (4) begin tick(); obs(a, rw, wd); end
      end
    end
    bus_rdy = 1'b1;
    stretches = dfalls - 1;
  endtask

  logic [7:0] rd;
  logic       err, done;
  int         st;

  initial begin
    rom[15'h0000] = 8'h4C;
    rom[ROM_LAST[14:0]] = 8'hEA;
    rst = 1'b0; phi_0 = 1'b1; bus_rdy = 1'b1;
    req_valid = 1'b0; req_rw = RW_READ; req_addr = '0; req_wdata = '0;
    tick(); tick();
    chk("rst_addr", bus_addr, 16'h0000);
    chk("rst_rw", bus_rw, 1);
    chk("rst_wdata", bus_wdata, 0);
    chk("rst_oe", bus_data_oe, 0);
    chk("rst_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_err", rsp_err, 0);
    rst = 1'b1; tick();

    // ROM read, with a mid-period accept that must not touch the bus
    phi_0 = 1'b1; tick();
    req_valid = 1'b1; req_rw = RW_READ; req_addr = 16'h8000; tick();
    req_valid = 1'b0;
    chk("pend_ready", req_ready, 0);
    chk("pend_bus_quiet", bus_addr, 16'h0000);
    phi_0 = 1'b0; tick();
    chk("rom_addr_fall", bus_addr, 16'h8000);
    chk("rom_rw_fall", bus_rw, 1);
    repeat (3) tick();
    phi_0 = 1'b1; repeat (4) tick();
    phi_0 = 1'b0; tick();
    chk("rom_rsp_valid", rsp_valid, 1);
    chk("rom_rdata", rsp_rdata, 8'h4C);
    chk("rom_err", rsp_err, 0);
    chk("rom_ready_after", req_ready, 1);
    tick();
    chk("rom_rsp_pulse", rsp_valid, 0);
    chk("rom_rdata_held", rsp_rdata, 8'h4C);

    // SRAM write/read at both ends
    xfer(RW_WRITE, SRAM_BASE, 8'hAA, 0, rd, err, st, done);
    chk("wr0_done", done, 1);
    chk("wr0_oe", oe_s, 1);
    chk("wr0_wdata", wd_ok, 1);
    chk("wr0_rw_fall", rw_fall, 0);
    chk("wr0_oe_end", bus_data_oe, 0);
    chk("wr0_rw_end", bus_rw, 1);
    chk("wr0_addr_hold", bus_addr, 16'h0000);
    xfer(RW_READ, SRAM_BASE, 8'h00, 0, rd, err, st, done);
    chk("rd0_data", rd, 8'hAA);
    chk("rd0_oe", oe_s, 0);
    xfer(RW_WRITE, 16'h1FFF, 8'h55, 0, rd, err, st, done);
    chk("wr1_oe", oe_s, 1);
    xfer(RW_READ, 16'h1FFF, 8'h00, 0, rd, err, st, done);
    chk("rd1_data", rd, 8'h55);

    // Writes ignore RDY
    xfer(RW_WRITE, 16'h0010, 8'h3C, 2, rd, err, st, done);
    chk("wr_rdy_stretch", st, 0);
    chk("wr_rdy_err", err, 0);

    // Read stretched by 3 low-RDY falls
    xfer(RW_READ, 16'h0010, 8'h00, 3, rd, err, st, done);
    chk("ws_done", done, 1);
    chk("ws_stretch", st, 3);
    chk("ws_addr_stable", a_ok, 1);
    chk("ws_data", rd, 8'h3C);
    chk("ws_err", err, 0);

    // RDY stuck low: MAX_WAIT=4 stretched periods then error
    xfer(RW_READ, 16'h8000, 8'h00, 99, rd, err, st, done);
    chk("to_done", done, 1);
    chk("to_stretch", st, 4);
    chk("to_err", err, 1);
    chk("to_rdata", rd, 8'h00);
    chk("to_ready", req_ready, 1);

    // Unmapped hole floats high
    xfer(RW_READ, 16'h4000, 8'h00, 0, rd, err, st, done);
    chk("um_data", rd, 8'hFF);
    chk("um_err", err, 0);

    // Reset during the DATA phase of a write
    phi_0 = 1'b1; tick(); tick();
    req_valid = 1'b1; req_rw = RW_WRITE; req_addr = 16'h0005; req_wdata = 8'h77; tick();
    req_valid = 1'b0;
    phi_0 = 1'b0; tick();
    chk("mr_oe_addr", bus_data_oe, 1);
    repeat (3) tick();
    phi_0 = 1'b1; tick(); tick();
    rst = 1'b0; tick();
    chk("mr_oe", bus_data_oe, 0);
    chk("mr_rw", bus_rw, 1);
    chk("mr_ready", req_ready, 1);
    chk("mr_rsp", rsp_valid, 0);
    rst = 1'b1;
    phi_0 = 1'b0; tick();
    chk("mr_no_rsp", rsp_valid, 0);
    tick();
    chk("mr_no_rsp2", rsp_valid, 0);

    // Recovery after reset
    xfer(RW_READ, ROM_LAST, 8'h00, 0, rd, err, st, done);
    chk("rec_data", rd, 8'hEA);
    chk("rec_addr", a_ok, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
